// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the FP command scheduler.
package fp_sched_pkg;

  localparam int CMD_W   = 66;
  localparam int FRAME_W = 104;

  // Scheduler state encodings; anything else is treated as IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WAIT_FP = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  localparam logic [1:0]  OP_ADD    = 2'b00;
  localparam logic [1:0]  OP_SUB    = 2'b01;
  localparam logic [1:0]  OP_MUL    = 2'b10;
  localparam logic [1:0]  OP_RSVD   = 2'b11;

  localparam logic [5:0]  ACK_START = 6'b111111;
  localparam logic [31:0] QNAN      = 32'h7FC00000;

  // Result frame sent to the I2C master: start marker, echoed command, result.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [CMD_W-1:0] cmd,
                                                     input logic [31:0]      res);
    return {ACK_START, cmd, res};
  endfunction

endpackage

// File: rtl/fp_cmd_scheduler_cmd_fifo.sv
// Synchronous FIFO with full/empty/level; writes are refused while full.
module cmd_fifo #(
  parameter  int WIDTH = 66,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == LW'(0));
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; contents are don't-care while empty so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_level  <= LW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fp_cmd_scheduler.sv
// Serialises queued FP commands: issue to the FP unit, wait for the result,
// then hand the result frame to the I2C transmitter.
module fp_cmd_scheduler
  import fp_sched_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int FP_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  input  logic [CMD_W-1:0]             cmd_data,
  output logic                         cmd_ready,
  output logic                         fp_start,
  output logic [1:0]                   fp_op,
  output logic [31:0]                  fp_a,
  output logic [31:0]                  fp_b,
  input  logic                         fp_done,
  input  logic [31:0]                  fp_result,
  output logic                         tx_start,
  output logic [FRAME_W-1:0]           tx_frame,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic                         busy,
  output logic                         err_opcode,
  output logic                         err_timeout,
  output logic [$clog2(DEPTH+1)-1:0]   queue_level,
  output logic [2:0]                   state_dbg
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = $clog2(FP_TIMEOUT + 1);

  state_t             r_state, w_state_nxt;
  logic [CMD_W-1:0]   r_cur, w_cur_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [FRAME_W-1:0] r_frame, w_frame_nxt;
  logic               r_fp_start, w_fp_start_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic               r_err_op, w_err_op_nxt;
  logic               r_err_to, w_err_to_nxt;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [CMD_W-1:0]   w_head;
  logic [LW-1:0]      w_level;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd_valid),
    .i_wdata (cmd_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign cmd_ready   = !w_full;
  assign queue_level = w_level;
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign state_dbg   = r_state;
  assign fp_start    = r_fp_start;
  assign fp_op       = r_cur[CMD_W-1 -: 2];
  assign fp_a        = r_cur[63:32];
  assign fp_b        = r_cur[31:0];
  assign tx_start    = r_tx_start;
  assign tx_frame    = r_frame;
  assign err_opcode  = r_err_op;
  assign err_timeout = r_err_to;

  // Next-state and next-register values; fp_done beats a same-cycle timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_cnt_nxt      = r_cnt;
    w_frame_nxt    = r_frame;
    w_fp_start_nxt = 1'b0;
    w_tx_start_nxt = 1'b0;
    w_err_op_nxt   = 1'b0;
    w_err_to_nxt   = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cur_nxt   = w_head;
          w_state_nxt = ST_DECODE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (r_cur[CMD_W-1 -: 2] == OP_RSVD) begin
          w_err_op_nxt = 1'b1;
          w_frame_nxt  = build_frame(r_cur, 32'h0000_0000);
          w_state_nxt  = ST_SEND;
        end else begin
          w_fp_start_nxt = 1'b1;
          w_cnt_nxt      = CW'(0);
          w_state_nxt    = ST_WAIT_FP;
        end
      end
      ST_WAIT_FP: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (fp_done) begin
          w_frame_nxt = build_frame(r_cur, fp_result);
          w_state_nxt = ST_SEND;
        end else if (r_cnt == CW'(FP_TIMEOUT - 1)) begin
          w_err_to_nxt = 1'b1;
          w_frame_nxt  = build_frame(r_cur, QNAN);
          w_state_nxt  = ST_SEND;
        end else begin
          w_state_nxt = ST_WAIT_FP;
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ST_WAIT_TX;
        end else begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_WAIT_TX: begin
        if (tx_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_TX;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cur      <= {CMD_W{1'b0}};
      r_cnt      <= CW'(0);
      r_frame    <= {FRAME_W{1'b0}};
      r_fp_start <= 1'b0;
      r_tx_start <= 1'b0;
      r_err_op   <= 1'b0;
      r_err_to   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur      <= w_cur_nxt;
      r_cnt      <= w_cnt_nxt;
      r_frame    <= w_frame_nxt;
      r_fp_start <= w_fp_start_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_err_op   <= w_err_op_nxt;
      r_err_to   <= w_err_to_nxt;
    end
  end

endmodule

// File: tb/tb_fp_cmd_scheduler.sv
// Directed bench for fp_cmd_scheduler with a transaction-level scoreboard.
module tb_fp_cmd_scheduler;
  import fp_sched_pkg::*;

  localparam int DEPTH      = 4;
  localparam int FP_TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [65:0]   cmd_data;
  logic          fp_start, fp_done, tx_start, tx_done, tx_busy, busy;
  logic [1:0]    fp_op;
  logic [31:0]   fp_a, fp_b, fp_result;
  logic [103:0]  tx_frame;
  logic          err_opcode, err_timeout;
  logic [2:0]    queue_level;
  logic [2:0]    state_dbg;
  logic          resp_fp_done, stray_fp, resp_tx_done, stray_tx;

  assign fp_done = resp_fp_done | stray_fp;
  assign tx_done = resp_tx_done | stray_tx;

  always #5 clk = ~clk;

  fp_cmd_scheduler #(.DEPTH(DEPTH), .FP_TIMEOUT(FP_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .fp_start(fp_start), .fp_op(fp_op), .fp_a(fp_a),
    .fp_b(fp_b), .fp_done(fp_done), .fp_result(fp_result), .tx_start(tx_start),
    .tx_frame(tx_frame), .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy),
    .err_opcode(err_opcode), .err_timeout(err_timeout),
    .queue_level(queue_level), .state_dbg(state_dbg)
  );

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: commands expected at the FP port, frames expected at the I2C port.
  logic [65:0]  q_issue[$];
  logic [103:0] q_frame[$];
  bit           fp_never = 1'b0;
  bit           tx_auto  = 1'b1;
  int           fp_pend = 0, tx_pend = 0;
  logic [31:0]  pend_res;
  int           fp_start_cyc = 0, tx_start_cyc = 0, acc_edge = 0;
  int           n_fp_start = 0, n_tx_start = 0, n_err_op = 0, n_err_to = 0;
  logic [103:0] last_frame = '0, held = '0;
  bit           hold = 1'b0, prev_fp = 1'b0;
  logic [65:0]  cmp_cmd;
  logic [103:0] cmp_frame;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // Stand-in FP unit: known IEEE answers for the directed operands, otherwise a tag.
  function automatic logic [31:0] fp_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 2'b00 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return a ^ b ^ {30'd0, op};
  endfunction

  function automatic logic [31:0] exp_result(input logic [65:0] c);
    if (c[65:64] == 2'b11) return 32'h0;
    if (fp_never) return 32'h7FC00000;
    return fp_ref(c[65:64], c[63:32], c[31:0]);
  endfunction

  // FP responder: fp_done one cycle after fp_start unless told never to answer.
  initial begin
    resp_fp_done = 1'b0; fp_result = 32'h0;
    forever begin
      @(negedge clk);
      resp_fp_done = 1'b0;
      if (fp_pend > 0) begin
        fp_pend--;
        if (fp_pend == 0) begin resp_fp_done = 1'b1; fp_result = pend_res; end
      end
      if (fp_start && !fp_never && !reset) begin
        fp_pend = 1; pend_res = fp_ref(fp_op, fp_a, fp_b);
      end
    end
  end

  // I2C responder: tx_done three cycles after tx_start when auto mode is on.
  initial begin
    resp_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      resp_tx_done = 1'b0;
      if (tx_pend > 0) begin
        tx_pend--;
        if (tx_pend == 0) resp_tx_done = 1'b1;
      end
      if (tx_start && tx_auto && !reset) tx_pend = 3;
    end
  end

  // Compare process: every issue, frame, error pulse and held frame against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (fp_start) begin
        n_fp_start++;
        chk("fp_start_width", prev_fp, 0);
        chk("fp_start_expected", q_issue.size() > 0, 1);
        if (q_issue.size() > 0) begin
          cmp_cmd = q_issue.pop_front();
          chk("fp_op", fp_op, cmp_cmd[65:64]);
          chk("fp_a", fp_a, cmp_cmd[63:32]);
          chk("fp_b", fp_b, cmp_cmd[31:0]);
        end
        fp_start_cyc = cyc;
      end
      if (err_timeout) begin
        n_err_to++;
        chk("timeout_latency", cyc - fp_start_cyc, FP_TIMEOUT);
      end
      if (err_opcode) n_err_op++;
      if (tx_start) begin
        n_tx_start++;
        tx_start_cyc = cyc;
        chk("tx_start_expected", q_frame.size() > 0, 1);
        if (q_frame.size() > 0) begin
          cmp_frame = q_frame.pop_front();
          chk("tx_frame", tx_frame, cmp_frame);
        end
        last_frame = tx_frame; held = tx_frame; hold = 1'b1;
      end else if (hold && state_dbg == 3'd4) begin
        chk("tx_frame_hold", tx_frame, held);
      end
      if (state_dbg == 3'd0) hold = 1'b0;
      prev_fp = fp_start;
    end else begin
      prev_fp = 1'b0; hold = 1'b0;
    end
  end

  task automatic offer(input logic [65:0] c);
    int waited = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_data = c;
    while (!cmd_ready && waited < 500) begin @(negedge clk); waited++; end
    chk("accept", cmd_ready, 1);
    if (cmd_ready) begin
      acc_edge = cyc + 1;
      q_frame.push_back({6'b111111, c, exp_result(c)});
      if (c[65:64] != 2'b11) q_issue.push_back(c);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string nm);
    int k = 0;
    while ((busy || q_frame.size() != 0) && k < max) begin @(negedge clk); k++; end
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_idle_frames_left"}, q_frame.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_fp_start"}, fp_start, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_err_opcode"}, err_opcode, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_fp_op_a_b"}, {fp_op, fp_a, fp_b}, 0);
    chk({tag, "_tx_frame"}, tx_frame, 0);
    chk({tag, "_queue_level"}, queue_level, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual no-finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b_fp, b_tx, b_op, k;
    logic [65:0] c;
    cmd_valid = 1'b0; cmd_data = '0; tx_busy = 1'b0; stray_fp = 1'b0; stray_tx = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 1.0 + 2.0 with an immediate FP answer
    offer({2'b00, 32'h3F800000, 32'h40000000});
    k = acc_edge;
    wait_idle(100, "t1");
    chk("t1_fp_start_edge", fp_start_cyc, k + 2);
    chk("t1_tx_start_edge", tx_start_cyc, k + 5);
    chk("t1_frame_literal", last_frame, 104'hFC3F8000004000000040400000);

    // 3: reserved opcode is reported and sent with a zero result, never issued
    b_fp = n_fp_start; b_op = n_err_op;
    offer({2'b11, 32'h12345678, 32'h9ABCDEF0});
    wait_idle(100, "t3");
    chk("t3_err_opcode_pulses", n_err_op - b_op, 1);
    chk("t3_no_fp_start", n_fp_start - b_fp, 0);
    chk("t3_frame_literal", last_frame, 104'hFF123456789ABCDEF000000000);

    // 4: FP unit never answers -> qNaN after the timeout
    fp_never = 1'b1;
    offer({2'b01, 32'h40A00000, 32'h3F800000});
    wait_idle(200, "t4");
    fp_never = 1'b0;
    chk("t4_err_timeout_pulses", n_err_to, 1);
    chk("t4_frame_literal", last_frame, 104'hFD40A000003F8000007FC00000);

    // 2: fill the FIFO behind a stalled transmitter, then drain in order
    tx_busy = 1'b1;
    b_tx = n_tx_start;
    for (int i = 0; i < 5; i++) begin
      c = {2'(i % 3), 32'h10000000 + 32'(i), 32'h20000000 + 32'(i)};
      offer(c);
    end
    repeat (6) @(negedge clk);
    chk("t2_level_full", queue_level, 4);
    chk("t2_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_data = {2'b10, 32'h3000_0006, 32'h4000_0006};
    repeat (10) @(negedge clk);
    chk("t2_level_still_full", queue_level, 4);
    chk("t2_stalled_in_send", state_dbg, 3);
    tx_busy = 1'b0;
    offer({2'b10, 32'h3000_0006, 32'h4000_0006});
    wait_idle(400, "t2");
    chk("t2_frames_sent", n_tx_start - b_tx, 6);

    // 5: tx_busy holds the frame in SEND; stray done pulses while idle are ignored
    tx_busy = 1'b1;
    b_tx = n_tx_start;
    offer({2'b10, 32'h40400000, 32'h40800000});
    repeat (24) @(negedge clk);
    chk("t5_no_tx_while_busy", n_tx_start - b_tx, 0);
    chk("t5_state_send", state_dbg, 3);
    tx_busy = 1'b0;
    k = cyc + 1;
    wait_idle(100, "t5");
    chk("t5_tx_start_edge", tx_start_cyc, k);
    b_fp = n_fp_start; b_tx = n_tx_start;
    @(negedge clk); stray_fp = 1'b1; stray_tx = 1'b1;
    @(negedge clk); stray_fp = 1'b0; stray_tx = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_stray_state", state_dbg, 0);
    chk("t5_stray_busy", busy, 0);
    chk("t5_stray_no_starts", (n_fp_start - b_fp) + (n_tx_start - b_tx), 0);

    // 6: reset while waiting on the transmitter with two commands queued
    tx_auto = 1'b0;
    offer({2'b00, 32'h00000011, 32'h00000022});
    offer({2'b01, 32'h00000033, 32'h00000044});
    offer({2'b10, 32'h00000055, 32'h00000066});
    k = 0;
    while (!(state_dbg == 3'd4 && queue_level == 3'd2) && k < 100) begin @(negedge clk); k++; end
    chk("t6_wait_tx_state", state_dbg, 4);
    chk("t6_two_queued", queue_level, 2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst6");
    q_issue.delete(); q_frame.delete();
    tx_auto = 1'b1;
    b_tx = n_tx_start;
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_no_tx_after_reset", n_tx_start - b_tx, 0);
    chk("t6_idle_after_reset", {busy, state_dbg, queue_level}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
